// File: rtl/pov_reg_spi_sched_if.sv
`timescale 1ns/1ps
// Requester-side bundle for pov_reg_spi_sched: two level-request channels in,
// two SPI ports plus busy/ack status out.
interface pov_reg_spi_sched_if #(
  parameter int POV_BITS = 74,
  parameter int REG_BITS = 14
) ();
  logic                vblank;
  logic                pov_req;
  logic [POV_BITS-1:0] pov_data;
  logic                pov_ack;
  logic                reg_req;
  logic [REG_BITS-1:0] reg_data;
  logic                reg_ack;
  logic                pov_sclk;
  logic                pov_mosi;
  logic                pov_ss_n;
  logic                reg_sclk;
  logic                reg_mosi;
  logic                reg_ss_n;
  logic                busy;

  modport master (
    output vblank, pov_req, pov_data, reg_req, reg_data,
    input  pov_ack, reg_ack, pov_sclk, pov_mosi, pov_ss_n,
           reg_sclk, reg_mosi, reg_ss_n, busy
  );

  modport slave (
    input  vblank, pov_req, pov_data, reg_req, reg_data,
    output pov_ack, reg_ack, pov_sclk, pov_mosi, pov_ss_n,
           reg_sclk, reg_mosi, reg_ss_n, busy
  );
endinterface

// File: rtl/pov_reg_spi_sched.sv
`timescale 1ns/1ps
// Shared SPI shift engine that serialises POV and register updates onto two
// SPI ports, one frame at a time, with round-robin arbitration and vblank gating.
module pov_reg_spi_sched #(
  parameter int POV_BITS    = 74,
  parameter int REG_BITS    = 14,
  parameter int HALF_DIV    = 2,
  parameter int VBLANK_SYNC = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  pov_reg_spi_sched_if.slave  bus
);

  localparam int MAX_BITS = (POV_BITS > REG_BITS) ? POV_BITS : REG_BITS;
  localparam int BIT_W    = $clog2(MAX_BITS + 1);
  localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [DIV_W-1:0]    r_divCnt;
  logic [BIT_W-1:0]    r_bitCnt;
  logic [MAX_BITS-1:0] r_shift;
  logic [MAX_BITS-1:0] w_nextShift;
  logic [MAX_BITS-1:0] w_povAligned;
  logic [MAX_BITS-1:0] w_regAligned;
  logic                r_selPov;
  logic                w_nextSelPov;
  logic                r_lastPov;
  logic                w_divDone;
  logic                w_lastBit;
  logic                w_eligible;
  logic                w_grant;
  logic                w_grantPov;

  logic r_povSclk, r_povMosi, r_povSsN, r_regSclk, r_regMosi, r_regSsN;
  logic r_povAck, r_regAck, r_busy;
  logic w_povSclkNxt, w_povMosiNxt, w_povSsNNxt;
  logic w_regSclkNxt, w_regMosiNxt, w_regSsNNxt;
  logic w_povAckNxt, w_regAckNxt, w_busyNxt;
  logic w_sclkNxt, w_ssActNxt, w_mosiNxt;

  assign w_divDone  = (r_divCnt == DIV_W'(HALF_DIV - 1));
  assign w_lastBit  = r_selPov ? (r_bitCnt == BIT_W'(POV_BITS - 1))
                               : (r_bitCnt == BIT_W'(REG_BITS - 1));
  assign w_eligible = (bus.pov_req | bus.reg_req) & (bus.vblank | (VBLANK_SYNC == 0));
  assign w_grant    = (r_state == S_IDLE) & w_eligible;
  // On a tie the port that did not win last time goes next.
  assign w_grantPov = bus.pov_req & (~bus.reg_req | ~r_lastPov);

  // Payloads are left-aligned so the MSB of either frame sits at the top bit.
  assign w_povAligned = MAX_BITS'(bus.pov_data) << (MAX_BITS - POV_BITS);
  assign w_regAligned = MAX_BITS'(bus.reg_data) << (MAX_BITS - REG_BITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_grant)   w_nextState = S_SETUP;
      S_SETUP: if (w_divDone) w_nextState = S_HIGH;
      S_HIGH:  if (w_divDone) w_nextState = w_lastBit ? S_HOLD : S_LOW;
      S_LOW:   if (w_divDone) w_nextState = S_HIGH;
      S_HOLD:  if (w_divDone) w_nextState = S_GAP;
      S_GAP:   if (w_divDone) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_nextShift  = r_shift;
    w_nextSelPov = r_selPov;
    if (w_grant) begin
      w_nextSelPov = w_grantPov;
      w_nextShift  = w_grantPov ? w_povAligned : w_regAligned;
    end else if ((r_state == S_HIGH) && (w_nextState == S_LOW)) begin
      w_nextShift = r_shift << 1;
    end
  end

  // Outputs are decoded from the upcoming state and registered on the same
  // edge as the state, so the pins always match the current state.
  always_comb begin
    w_sclkNxt    = (w_nextState == S_HIGH);
    w_ssActNxt   = (w_nextState == S_SETUP) || (w_nextState == S_HIGH) ||
                   (w_nextState == S_LOW)   || (w_nextState == S_HOLD);
    w_mosiNxt    = ((w_nextState == S_SETUP) || (w_nextState == S_HIGH) ||
                    (w_nextState == S_LOW)) & w_nextShift[MAX_BITS-1];
    w_povSclkNxt = w_nextSelPov & w_sclkNxt;
    w_povMosiNxt = w_nextSelPov & w_mosiNxt;
    w_povSsNNxt  = ~(w_nextSelPov & w_ssActNxt);
    w_regSclkNxt = ~w_nextSelPov & w_sclkNxt;
    w_regMosiNxt = ~w_nextSelPov & w_mosiNxt;
    w_regSsNNxt  = ~(~w_nextSelPov & w_ssActNxt);
    w_povAckNxt  = w_grant & w_grantPov;
    w_regAckNxt  = w_grant & ~w_grantPov;
    w_busyNxt    = (w_nextState != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divCnt  <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_selPov  <= 1'b0;
      r_lastPov <= 1'b0;
    end else begin
      r_divCnt <= ((r_state == S_IDLE) || w_divDone) ? '0 : r_divCnt + DIV_W'(1);
      if (w_grant) begin
        r_bitCnt  <= '0;
        r_lastPov <= w_grantPov;
      end else if ((r_state == S_HIGH) && w_divDone) begin
        r_bitCnt <= r_bitCnt + BIT_W'(1);
      end
      r_shift  <= w_nextShift;
      r_selPov <= w_nextSelPov;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_povSclk <= 1'b0;
      r_povMosi <= 1'b0;
      r_povSsN  <= 1'b1;
      r_regSclk <= 1'b0;
      r_regMosi <= 1'b0;
      r_regSsN  <= 1'b1;
      r_povAck  <= 1'b0;
      r_regAck  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_povSclk <= w_povSclkNxt;
      r_povMosi <= w_povMosiNxt;
      r_povSsN  <= w_povSsNNxt;
      r_regSclk <= w_regSclkNxt;
      r_regMosi <= w_regMosiNxt;
      r_regSsN  <= w_regSsNNxt;
      r_povAck  <= w_povAckNxt;
      r_regAck  <= w_regAckNxt;
      r_busy    <= w_busyNxt;
    end
  end

  assign bus.pov_sclk = r_povSclk;
  assign bus.pov_mosi = r_povMosi;
  assign bus.pov_ss_n = r_povSsN;
  assign bus.reg_sclk = r_regSclk;
  assign bus.reg_mosi = r_regMosi;
  assign bus.reg_ss_n = r_regSsN;
  assign bus.pov_ack  = r_povAck;
  assign bus.reg_ack  = r_regAck;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_pov_reg_spi_sched.sv
`timescale 1ns/1ps
// Directed self-checking bench for pov_reg_spi_sched: a default instance plus
// a HALF_DIV=1 instance, each scenario in its own task with inline checks.
module tb_pov_reg_spi_sched;

  localparam logic [73:0] P1 = 74'h3_A5C3_0FF0_1234_5678_9A;
  localparam logic [73:0] P2 = 74'h1_F00D_CAFE_8421_7BDE_65;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  int          m_idle, m_busy, m_povAcks, m_regAcks, m_povRises, m_regRises;
  int          m_povSsLow, m_regSsLow, m_povHigh, m_regHigh;
  logic [73:0] m_povBits;
  logic [13:0] m_regBits;
  bit          m_timeout, m_badIdle;

  pov_reg_spi_sched_if #(.POV_BITS(74), .REG_BITS(14)) bus ();
  pov_reg_spi_sched_if #(.POV_BITS(74), .REG_BITS(14)) bus1 ();

  pov_reg_spi_sched #(.POV_BITS(74), .REG_BITS(14), .HALF_DIV(2), .VBLANK_SYNC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pov_reg_spi_sched #(.POV_BITS(74), .REG_BITS(14), .HALF_DIV(1), .VBLANK_SYNC(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Observes one frame on the default instance: idle cycles before busy, then
  // every busy cycle up to and including the first idle cycle after it.
  task automatic measure_frame(input bit dropOnAck, input int vblankDropAt, input int budget);
    bit   started;
    bit   done;
    int   cyc;
    logic prevPov;
    logic prevReg;
    started = 0; done = 0; cyc = 0; prevPov = 0; prevReg = 0;
    m_idle = 0; m_busy = 0; m_povAcks = 0; m_regAcks = 0; m_povRises = 0; m_regRises = 0;
    m_povSsLow = 0; m_regSsLow = 0; m_povHigh = 0; m_regHigh = 0;
    m_povBits = '0; m_regBits = '0; m_badIdle = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.busy !== 1'b1) begin
        if (started) done = 1;
        else m_idle++;
      end else begin
        started = 1;
        m_busy++;
        if (m_busy - 1 == vblankDropAt) bus.vblank = 1'b0;
      end
      if (bus.pov_ack === 1'b1) m_povAcks++;
      if (bus.reg_ack === 1'b1) m_regAcks++;
      if (bus.pov_ss_n === 1'b0) m_povSsLow++;
      if (bus.reg_ss_n === 1'b0) m_regSsLow++;
      if (bus.pov_sclk === 1'b1) begin
        m_povHigh++;
        if (prevPov !== 1'b1) begin
          m_povRises++;
          m_povBits = {m_povBits[72:0], bus.pov_mosi};
        end
      end
      if (bus.reg_sclk === 1'b1) begin
        m_regHigh++;
        if (prevReg !== 1'b1) begin
          m_regRises++;
          m_regBits = {m_regBits[12:0], bus.reg_mosi};
        end
      end
      prevPov = bus.pov_sclk;
      prevReg = bus.reg_sclk;
      if ((bus.pov_ss_n === 1'b0 && bus.reg_ss_n === 1'b0) ||
          (bus.pov_ss_n === 1'b1 && (bus.pov_sclk !== 1'b0 || bus.pov_mosi !== 1'b0)) ||
          (bus.reg_ss_n === 1'b1 && (bus.reg_sclk !== 1'b0 || bus.reg_mosi !== 1'b0)))
        m_badIdle = 1;
      if (dropOnAck && bus.pov_ack === 1'b1) bus.pov_req = 1'b0;
      if (dropOnAck && bus.reg_ack === 1'b1) bus.reg_req = 1'b0;
    end
    m_timeout = !done;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    rst_n = 1'b0;
    bus.vblank = 0; bus.pov_req = 0; bus.reg_req = 0; bus.pov_data = '0; bus.reg_data = '0;
    bus1.vblank = 0; bus1.pov_req = 0; bus1.reg_req = 0; bus1.pov_data = '0; bus1.reg_data = '0;
    repeat (3) @(negedge clk);
    obs = {bus.busy, bus.pov_ack, bus.reg_ack, bus.pov_sclk, bus.pov_mosi, bus.pov_ss_n,
           bus.reg_sclk, bus.reg_mosi, bus.reg_ss_n};
    checks++;
    if (obs !== 9'b000_001_001) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 9'b000_001_001);
    end
    obs = {bus1.busy, bus1.pov_ack, bus1.reg_ack, bus1.pov_sclk, bus1.pov_mosi, bus1.pov_ss_n,
           bus1.reg_sclk, bus1.reg_mosi, bus1.reg_ss_n};
    checks++;
    if (obs !== 9'b000_001_001) begin
      errors++; $display("[TB] FAIL reset_outputs_hd1: got %b expected %b", obs, 9'b000_001_001);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_after_release: busy got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_arbitration();
    bus.vblank = 1; bus.pov_data = P1; bus.reg_data = 14'h2A5C;
    bus.pov_req = 1; bus.reg_req = 1;
    measure_frame(0, -1, 1000);
    checks++;
    if (m_timeout) begin errors++; $display("[TB] FAIL arb_f1_timeout: got timeout expected frame end"); end
    checks++;
    if (m_povAcks * 10 + m_regAcks !== 10) begin
      errors++; $display("[TB] FAIL arb_first_grant: got pov=%0d reg=%0d expected pov=1 reg=0", m_povAcks, m_regAcks);
    end
    checks++;
    if (m_busy !== 300) begin errors++; $display("[TB] FAIL arb_pov_busy: got %0d expected 300", m_busy); end
    checks++;
    if (m_povRises !== 74) begin errors++; $display("[TB] FAIL arb_pov_rises: got %0d expected 74", m_povRises); end
    checks++;
    if (m_povBits !== P1) begin errors++; $display("[TB] FAIL arb_pov_bits: got %h expected %h", m_povBits, P1); end
    checks++;
    if (m_regSsLow !== 0 || m_badIdle) begin
      errors++; $display("[TB] FAIL arb_other_port_idle: got regSsLow=%0d bad=%0d expected 0 0", m_regSsLow, m_badIdle);
    end
    measure_frame(0, -1, 1000);
    checks++;
    if (m_povAcks * 10 + m_regAcks !== 1) begin
      errors++; $display("[TB] FAIL arb_second_grant: got pov=%0d reg=%0d expected pov=0 reg=1", m_povAcks, m_regAcks);
    end
    checks++;
    if (m_idle !== 0) begin errors++; $display("[TB] FAIL arb_gap_f2: got %0d idle cycles expected 0", m_idle); end
    checks++;
    if (m_busy !== 60) begin errors++; $display("[TB] FAIL arb_reg_busy: got %0d expected 60", m_busy); end
    measure_frame(0, -1, 1000);
    bus.pov_req = 0; bus.reg_req = 0;
    checks++;
    if (m_povAcks * 10 + m_regAcks !== 10) begin
      errors++; $display("[TB] FAIL arb_third_grant: got pov=%0d reg=%0d expected pov=1 reg=0", m_povAcks, m_regAcks);
    end
    checks++;
    if (m_idle !== 0 || m_busy !== 300) begin
      errors++; $display("[TB] FAIL arb_f3_shape: got idle=%0d busy=%0d expected 0 300", m_idle, m_busy);
    end
  endtask

  task automatic test_reg_frame();
    bus.vblank = 1; bus.reg_data = 14'h2A5C; bus.reg_req = 1;
    measure_frame(1, -1, 300);
    checks++;
    if (m_timeout) begin errors++; $display("[TB] FAIL reg_timeout: got timeout expected frame end"); end
    checks++;
    if (m_regAcks !== 1 || m_povAcks !== 0) begin
      errors++; $display("[TB] FAIL reg_ack_count: got reg=%0d pov=%0d expected 1 0", m_regAcks, m_povAcks);
    end
    checks++;
    if (m_regSsLow !== 58) begin errors++; $display("[TB] FAIL reg_ss_low: got %0d expected 58", m_regSsLow); end
    checks++;
    if (m_busy !== 60) begin errors++; $display("[TB] FAIL reg_busy: got %0d expected 60", m_busy); end
    checks++;
    if (m_regRises !== 14) begin errors++; $display("[TB] FAIL reg_rises: got %0d expected 14", m_regRises); end
    checks++;
    if (m_regBits !== 14'h2A5C) begin errors++; $display("[TB] FAIL reg_bits: got %h expected 2a5c", m_regBits); end
    checks++;
    if (m_regHigh !== 28) begin errors++; $display("[TB] FAIL reg_sclk_high: got %0d expected 28", m_regHigh); end
    checks++;
    if (m_povSsLow !== 0 || m_povRises !== 0 || m_badIdle) begin
      errors++; $display("[TB] FAIL reg_pov_idle: got ssLow=%0d rises=%0d bad=%0d expected 0 0 0",
                         m_povSsLow, m_povRises, m_badIdle);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reg_no_regrant: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_vblank();
    int activity;
    activity = 0;
    bus.vblank = 0; bus.pov_data = P1; bus.pov_req = 1;
    repeat (100) begin
      @(negedge clk);
      if (bus.pov_ack !== 1'b0 || bus.busy !== 1'b0 || bus.pov_ss_n !== 1'b1 || bus.pov_sclk !== 1'b0)
        activity++;
    end
    checks++;
    if (activity !== 0) begin errors++; $display("[TB] FAIL vblank_gate: got %0d active cycles expected 0", activity); end
    bus.vblank = 1;
    measure_frame(1, 5, 1000);
    bus.vblank = 1;
    checks++;
    if (m_idle !== 0 || m_povAcks !== 1) begin
      errors++; $display("[TB] FAIL vblank_ack: got idle=%0d acks=%0d expected 0 1", m_idle, m_povAcks);
    end
    checks++;
    if (m_timeout || m_busy !== 300) begin
      errors++; $display("[TB] FAIL vblank_frame_len: got %0d timeout=%0d expected 300", m_busy, m_timeout);
    end
    checks++;
    if (m_povRises !== 74 || m_povBits !== P1) begin
      errors++; $display("[TB] FAIL vblank_bits: got rises=%0d bits=%h expected 74 %h", m_povRises, m_povBits, P1);
    end
  endtask

  task automatic test_back_to_back();
    bit sawAck;
    bit ended;
    int busyCnt;
    int regAct;
    sawAck = 0; ended = 0; busyCnt = 10; regAct = 0;
    bus.vblank = 1; bus.pov_data = P2; bus.pov_req = 1;
    for (int c = 0; c < 20 && !sawAck; c++) begin
      @(negedge clk);
      if (bus.pov_ack === 1'b1) sawAck = 1;
    end
    bus.pov_req = 0;
    checks++;
    if (!sawAck) begin errors++; $display("[TB] FAIL wait_pov_ack: got no ack expected ack"); end
    repeat (9) @(negedge clk);
    bus.reg_data = 14'h0F3C; bus.reg_req = 1;
    for (int c = 0; c < 400 && !ended; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) ended = 1;
      else busyCnt++;
      if (bus.reg_ack !== 1'b0 || bus.reg_sclk !== 1'b0 || bus.reg_ss_n !== 1'b1) regAct++;
    end
    checks++;
    if (busyCnt !== 300) begin errors++; $display("[TB] FAIL wait_pov_len: got %0d expected 300", busyCnt); end
    checks++;
    if (regAct !== 0) begin errors++; $display("[TB] FAIL wait_reg_early: got %0d active cycles expected 0", regAct); end
    measure_frame(1, -1, 200);
    checks++;
    if (m_idle !== 0 || m_regAcks !== 1) begin
      errors++; $display("[TB] FAIL wait_reg_ack_timing: got idle=%0d acks=%0d expected 0 1", m_idle, m_regAcks);
    end
    checks++;
    if (m_busy !== 60 || m_regRises !== 14 || m_regBits !== 14'h0F3C) begin
      errors++; $display("[TB] FAIL wait_reg_frame: got busy=%0d rises=%0d bits=%h expected 60 14 0f3c",
                         m_busy, m_regRises, m_regBits);
    end
  endtask

  task automatic test_reset_midframe();
    int         rises;
    logic       prev;
    logic [8:0] obs;
    rises = 0; prev = 0;
    bus.vblank = 1; bus.pov_data = P2; bus.pov_req = 1;
    for (int c = 0; c < 400 && rises < 20; c++) begin
      @(negedge clk);
      if (bus.pov_sclk === 1'b1 && prev !== 1'b1) rises++;
      prev = bus.pov_sclk;
    end
    checks++;
    if (rises !== 20 || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_reach_bit20: got rises=%0d busy=%b expected 20 1", rises, bus.busy);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    obs = {bus.busy, bus.pov_ack, bus.reg_ack, bus.pov_sclk, bus.pov_mosi, bus.pov_ss_n,
           bus.reg_sclk, bus.reg_mosi, bus.reg_ss_n};
    checks++;
    if (obs !== 9'b000_001_001) begin
      errors++; $display("[TB] FAIL midrst_async: got %b expected %b", obs, 9'b000_001_001);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    measure_frame(1, -1, 1000);
    checks++;
    if (m_timeout || m_povAcks !== 1 || m_busy !== 300) begin
      errors++; $display("[TB] FAIL midrst_refire: got acks=%0d busy=%0d timeout=%0d expected 1 300 0",
                         m_povAcks, m_busy, m_timeout);
    end
    checks++;
    if (m_povRises !== 74 || m_povBits !== P2) begin
      errors++; $display("[TB] FAIL midrst_bits: got rises=%0d bits=%h expected 74 %h", m_povRises, m_povBits, P2);
    end
  endtask

  task automatic test_halfdiv1();
    bit          started;
    bit          done;
    int          busyCnt, rises, acks, lastRise, minInt, maxInt;
    logic        prev;
    logic [13:0] bits;
    started = 0; done = 0; busyCnt = 0; rises = 0; acks = 0; lastRise = -1;
    minInt = 1000; maxInt = 0; prev = 0; bits = '0;
    bus1.vblank = 1; bus1.reg_data = 14'h1234; bus1.reg_req = 1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (bus1.busy !== 1'b1) begin
        if (started) done = 1;
      end else begin
        started = 1;
        busyCnt++;
      end
      if (bus1.reg_ack === 1'b1) begin
        acks++;
        bus1.reg_req = 0;
      end
      if (bus1.reg_sclk === 1'b1 && prev !== 1'b1) begin
        rises++;
        bits = {bits[12:0], bus1.reg_mosi};
        if (lastRise >= 0) begin
          if (c - lastRise < minInt) minInt = c - lastRise;
          if (c - lastRise > maxInt) maxInt = c - lastRise;
        end
        lastRise = c;
      end
      prev = bus1.reg_sclk;
    end
    checks++;
    if (!done || busyCnt !== 30) begin
      errors++; $display("[TB] FAIL hd1_busy: got %0d done=%0d expected 30", busyCnt, done);
    end
    checks++;
    if (rises !== 14 || acks !== 1) begin
      errors++; $display("[TB] FAIL hd1_rises_acks: got rises=%0d acks=%0d expected 14 1", rises, acks);
    end
    checks++;
    if (minInt !== 2 || maxInt !== 2) begin
      errors++; $display("[TB] FAIL hd1_sclk_period: got min=%0d max=%0d expected 2 2", minInt, maxInt);
    end
    checks++;
    if (bits !== 14'h1234) begin errors++; $display("[TB] FAIL hd1_bits: got %h expected 1234", bits); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_arbitration();
    test_reg_frame();
    test_vblank();
    test_back_to_back();
    test_reset_midframe();
    test_halfdiv1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
